// File: rtl/scale_controller.sv
// Scale controller: validates scaling commands, computes output geometry and
// sequences the data-processing engine. Optional SCALE_CYCLE_COUNTER_EN adds CYCLE_COUNT.
`timescale 1ns/1ps

module scale_controller #(
  parameter int unsigned MAX_WIDTH      = 640,
  parameter int unsigned MAX_HEIGHT     = 480,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [2:0]  CMD_OPCODE,
  input  logic [1:0]  CMD_FACTOR,
  input  logic [10:0] IN_WIDTH,
  input  logic [9:0]  IN_HEIGHT,
  output logic        PROC_ENABLE,
  output logic [1:0]  PROC_ALGORITHM,
  output logic [1:0]  PROC_SHIFT,
  output logic [10:0] PROC_WIDTH_OUT,
  output logic [9:0]  PROC_HEIGHT_OUT,
  input  logic        PROC_DONE,
  output logic        BUSY,
  output logic        DONE_FLAG,
  output logic        ERROR,
  output logic [1:0]  ERR_CODE
`ifdef SCALE_CYCLE_COUNTER_EN
  ,
  output logic [31:0] CYCLE_COUNT
`endif
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CHECK    = 3'd1;
  localparam logic [2:0] S_START    = 3'd2;
  localparam logic [2:0] S_WAIT     = 3'd3;
  localparam logic [2:0] S_RELEASE  = 3'd4;
  localparam logic [2:0] S_COMPLETE = 3'd5;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_NN    = 3'd1;
  localparam logic [2:0] OP_PR    = 3'd2;
  localparam logic [2:0] OP_BA    = 3'd4;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]      r_state;
  logic [2:0]      w_state_nxt;
  logic [2:0]      r_op;
  logic [1:0]      r_factor;
  logic [10:0]     r_in_w;
  logic [9:0]      r_in_h;
  logic            r_proc_en;
  logic [1:0]      r_alg;
  logic [1:0]      r_shift;
  logic [10:0]     r_w_out;
  logic [9:0]      r_h_out;
  logic            r_done;
  logic            r_err;
  logic [1:0]      r_err_code;
  logic            r_timeout;
  logic [WD_W-1:0] r_wd;
  logic [WD_W-1:0] w_wd_nxt;

  logic w_accept;
  logic w_is_scale_op;
  logic w_illegal;
  logic w_start;
  logic w_clear;
  logic w_upscale;
  logic w_dim_bad;
  logic w_wd_expire;
  logic [13:0] w_w14;
  logic [13:0] w_h14;
  logic [13:0] w_w_calc;
  logic [13:0] w_h_calc;

  // Command decode is only meaningful while idle; other states ignore the host.
  assign w_accept      = CMD_VALID && (r_state == S_IDLE);
  assign w_is_scale_op = (CMD_OPCODE >= OP_NN) && (CMD_OPCODE <= OP_BA);
  assign w_illegal     = w_accept && ((CMD_OPCODE == 3'd5) || (CMD_OPCODE == 3'd6) ||
                                      (w_is_scale_op && (CMD_FACTOR == 2'd0)));
  assign w_start       = w_accept && w_is_scale_op && (CMD_FACTOR != 2'd0);
  assign w_clear       = w_accept && (CMD_OPCODE == OP_CLEAR);

  assign w_upscale = (r_op == OP_NN) || (r_op == OP_PR);
  assign w_w14     = {3'b000, r_in_w};
  assign w_h14     = {4'b0000, r_in_h};
  assign w_w_calc  = w_upscale ? (w_w14 << r_factor) : (w_w14 >> r_factor);
  assign w_h_calc  = w_upscale ? (w_h14 << r_factor) : (w_h14 >> r_factor);
  assign w_dim_bad = (w_w_calc > 14'(MAX_WIDTH)) || (w_h_calc > 14'(MAX_HEIGHT)) ||
                     (w_w_calc == '0) || (w_h_calc == '0);

  assign w_wd_nxt    = r_wd + WD_W'(1);
  assign w_wd_expire = (r_state == S_WAIT) && (w_wd_nxt >= WD_W'(TIMEOUT_CYCLES));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (w_start) w_state_nxt = S_CHECK;
      S_CHECK:    w_state_nxt = w_dim_bad ? S_IDLE : S_START;
      S_START:    w_state_nxt = S_WAIT;
      S_WAIT:     if (PROC_DONE || w_wd_expire) w_state_nxt = S_RELEASE;
      S_RELEASE:  if (!PROC_DONE) w_state_nxt = r_timeout ? S_IDLE : S_COMPLETE;
      S_COMPLETE: w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_op     <= OP_NOP;
      r_factor <= '0;
      r_in_w   <= '0;
      r_in_h   <= '0;
    end else if (w_start) begin
      r_op     <= CMD_OPCODE;
      r_factor <= CMD_FACTOR;
      r_in_w   <= IN_WIDTH;
      r_in_h   <= IN_HEIGHT;
    end
  end

  // Engine-facing configuration is loaded once in CHECK and then held.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_alg   <= '0;
      r_shift <= '0;
      r_w_out <= '0;
      r_h_out <= '0;
    end else if (r_state == S_CHECK) begin
      r_alg   <= 2'(r_op - 3'd1);
      r_shift <= r_factor;
      r_w_out <= w_w_calc[10:0];
      r_h_out <= w_h_calc[9:0];
    end
  end

  // Enable is a flop decoded from the next state, so it is high exactly in START/WAIT.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_proc_en <= 1'b0;
    end else begin
      r_proc_en <= (w_state_nxt == S_START) || (w_state_nxt == S_WAIT);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else if (r_state == S_START) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else if (r_state == S_WAIT) begin
      r_wd <= w_wd_nxt;
      if (!PROC_DONE && w_wd_expire) r_timeout <= 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= '0;
    end else if (w_clear || w_start) begin
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= '0;
    end else if (w_illegal) begin
      r_err      <= 1'b1;
      r_err_code <= 2'd1;
    end else if ((r_state == S_CHECK) && w_dim_bad) begin
      r_err      <= 1'b1;
      r_err_code <= 2'd2;
    end else if ((r_state == S_WAIT) && !PROC_DONE && w_wd_expire) begin
      r_err      <= 1'b1;
      r_err_code <= 2'd3;
    end else if ((r_state == S_RELEASE) && (w_state_nxt == S_COMPLETE)) begin
      r_done <= 1'b1;
    end
  end

`ifdef SCALE_CYCLE_COUNTER_EN
  logic [31:0] r_cycles;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cycles <= '0;
    end else if (w_start) begin
      r_cycles <= '0;
    end else if (((r_state == S_START) || (r_state == S_WAIT) || (r_state == S_RELEASE)) &&
                 (r_cycles != '1)) begin
      r_cycles <= r_cycles + 32'd1;
    end
  end

  assign CYCLE_COUNT = r_cycles;
`endif

  assign CMD_READY       = (r_state == S_IDLE);
  assign BUSY            = (r_state != S_IDLE);
  assign PROC_ENABLE     = r_proc_en;
  assign PROC_ALGORITHM  = r_alg;
  assign PROC_SHIFT      = r_shift;
  assign PROC_WIDTH_OUT  = r_w_out;
  assign PROC_HEIGHT_OUT = r_h_out;
  assign DONE_FLAG       = r_done;
  assign ERROR           = r_err;
  assign ERR_CODE        = r_err_code;

endmodule

// File: doc/scale_controller.md
SCALE_CONTROLLER -- requirements
Module: scale_controller

Interface
REQ-001 Parameters:
- MAX_WIDTH, 640, largest legal output width in pixels.
- MAX_HEIGHT, 480, largest legal output height in lines.
- TIMEOUT_CYCLES, 2000000, watchdog limit in WAIT_DONE.

REQ-002 Ports, in order:
- CLK  in  1  clock, all logic on rising edge.
- RESET  in  1  reset, asynchronous, active-high.
- CMD_VALID  in  1  command strobe from host.
- CMD_READY  out  1  controller can accept a command.
- CMD_OPCODE  in  3  0 NOP, 1 NN, 2 PR, 3 DC, 4 BA, 7 CLEAR; 5 and 6 illegal.
- CMD_FACTOR  in  2  scale exponent 1..3 (x2/x4/x8); 0 is illegal.
- IN_WIDTH  in  11  source width.
- IN_HEIGHT  in  10  source height.
- PROC_ENABLE  out  1  enable to the data-processing engine.
- PROC_ALGORITHM  out  2  0 NN, 1 PR, 2 DC, 3 BA.
- PROC_SHIFT  out  2  latched factor.
- PROC_WIDTH_OUT  out  11  computed output width.
- PROC_HEIGHT_OUT  out  10  computed output height.
- PROC_DONE  in  1  engine completion, level, held while engine enable is high.
- BUSY  out  1  operation in progress.
- DONE_FLAG  out  1  sticky completion flag.
- ERROR  out  1  sticky error flag.
- ERR_CODE  out  2  1 illegal command, 2 dimension overflow/zero, 3 timeout.

Function
REQ-003 Handshake: a command is accepted on a rising edge with CMD_VALID=1 and CMD_READY=1; CMD_READY=1 only in IDLE.
REQ-004 States: IDLE, CHECK, START, WAIT_DONE, RELEASE, COMPLETE.
REQ-005 Accepted NOP:
- No state change.
- CMD_READY stays 1.
REQ-006 Accepted CLEAR:
- Clears DONE_FLAG, ERROR and ERR_CODE on the next edge.
- FSM remains in IDLE.
REQ-007 Accepted opcode 1-4:
- Latches opcode, factor, IN_WIDTH and IN_HEIGHT.
- Clears DONE_FLAG and ERROR.
- Goes to CHECK.
REQ-008 Accepted opcode 5/6, or factor 0:
- ERROR=1, ERR_CODE=1.
- FSM remains in IDLE.
- PROC_ENABLE is never asserted.
REQ-009 CHECK, one cycle:
- NN/PR: out = in << factor.
- DC/BA: out = in >> factor.
- Computation uses 14-bit intermediates, no truncation before comparison.
- PROC_WIDTH_OUT and PROC_HEIGHT_OUT are registered.
REQ-010 CHECK failure:
- Condition: width > MAX_WIDTH, height > MAX_HEIGHT, or either result = 0.
- Sets ERROR=1, ERR_CODE=2 and returns to IDLE.
- Otherwise the FSM goes to START.
REQ-011 PROC_ALGORITHM = latched opcode - 1; PROC_ALGORITHM, PROC_SHIFT and the dimension outputs are stable from CHECK exit until the return to IDLE.
REQ-012 START, one cycle: PROC_ENABLE is asserted and the watchdog counter is cleared; the FSM then goes to WAIT_DONE.
REQ-013 WAIT_DONE:
- PROC_ENABLE held at 1; watchdog increments each cycle.
- PROC_DONE=1 -> RELEASE.
- Watchdog reaches TIMEOUT_CYCLES -> RELEASE with ERROR=1, ERR_CODE=3.
- If PROC_DONE and timeout occur in the same cycle, PROC_DONE wins (no error).
REQ-014 RELEASE:
- PROC_ENABLE=0.
- Stays until PROC_DONE=0, then goes to COMPLETE, or to IDLE if a timeout occurred.
REQ-015 COMPLETE, one cycle: DONE_FLAG is set to 1 and the FSM goes to IDLE.
REQ-016 BUSY=1 in every state except IDLE; command inputs are ignored while BUSY=1.
REQ-017 PROC_ENABLE is registered and glitch-free; it is never 1 in IDLE, CHECK, RELEASE or COMPLETE.

Reset
REQ-018 On RESET:
- FSM in IDLE.
- PROC_ENABLE, BUSY, DONE_FLAG and ERROR = 0; ERR_CODE = 0.
- PROC_ALGORITHM, PROC_SHIFT, PROC_WIDTH_OUT and PROC_HEIGHT_OUT = 0.
- Watchdog = 0.
- CMD_READY = 1 on the first edge after release.
REQ-019 RESET asserted mid-operation drops PROC_ENABLE immediately (asynchronously) and discards the operation without setting DONE_FLAG.

Configuration
REQ-020 Macro SCALE_CYCLE_COUNTER_EN, when defined:
- Adds output port CYCLE_COUNT (out, 32 bits) after ERR_CODE.
- Cleared on command acceptance (REQ-007).
- Increments each cycle in START, WAIT_DONE and RELEASE; saturates at 0xFFFFFFFF.
- Holds its value in IDLE; reset value 0.
REQ-021 Macro SCALE_CYCLE_COUNTER_EN, when undefined: the port and its counter are absent, and all other behaviour is identical.

Verification
REQ-022 NN, factor 1, 160x120; PROC_DONE after 10 cycles in WAIT_DONE:
- Outputs: width 320, height 240, ALGORITHM 0.
- PROC_ENABLE high for 11 cycles.
- Then DONE_FLAG=1, BUSY=0.
REQ-023 BA, factor 2, 160x120 -> width 40, height 30, ALGORITHM 3, DONE_FLAG=1.
REQ-024 Overflow and illegal-command cases:
- PR, factor 3, 160x120: ERROR=1, ERR_CODE=2, PROC_ENABLE never 1.
- Opcode 5: ERROR=1, ERR_CODE=1.
REQ-025 TIMEOUT_CYCLES=16, PROC_DONE held 0:
- ERROR=1, ERR_CODE=3, PROC_ENABLE drops after 16 WAIT_DONE cycles.
- DONE_FLAG stays 0.
- Follow with CLEAR: flags return to 0.
REQ-026 RESET mid-WAIT_DONE -> PROC_ENABLE=0 immediately; next NN command completes normally.
REQ-027 With SCALE_CYCLE_COUNTER_EN, the REQ-022 run -> CYCLE_COUNT=13 (1 START + 10 WAIT_DONE + 2 RELEASE, with PROC_DONE dropping 1 cycle after enable falls).
